// File: rtl/ops_stim_check.sv
// Purpose: LFSR operand generator and result checker for the combinational operator block.
// Latency: 2 + settle cycles per vector (DRIVE, settle x SETTLE, CHECK); a run is max_vectors of those.
// Backpressure: none; start is honoured only in IDLE/DONE, and the DUT is assumed ready every cycle.
//
// Ports: clk/rst_n (async active-low); start pulse begins a run.
//        a/b/c are registered operands to the DUT; binary_* and qmark are the DUT results.
//        busy/done/pass give run status; vec_count/err_count/first_fail/fail_mask give statistics.
module ops_stim_check #(
  parameter int          width       = 4,
  parameter int          settle      = 1,
  parameter logic [31:0] seed        = 32'h0000_0321,
  parameter int          max_vectors = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [width-1:0] a,
  output logic [width-1:0] b,
  output logic [width-1:0] c,
  input  logic [width-1:0] binary_plus,
  input  logic [width-1:0] binary_minus,
  input  logic [width-1:0] binary_bitand,
  input  logic [width-1:0] binary_xor,
  input  logic [width-1:0] binary_shr,
  input  logic [width-1:0] qmark,
  input  logic             binary_eq,
  input  logic             binary_lt,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      vec_count,
  output logic [15:0]      err_count,
  output logic [15:0]      first_fail,
  output logic [7:0]       fail_mask
);

  // An all-zero LFSR would lock up, so a zero seed starts from 1 instead.
  localparam logic [31:0] SEED_EFF  = (seed == 32'd0) ? 32'd1 : seed;
  localparam logic [31:0] TAPS      = 32'h8020_0003;
  localparam int          SW        = (settle < 2) ? 1 : $clog2(settle + 1);
  localparam logic [SW-1:0] SETTLE_LD = SW'(settle);
  localparam logic [SW-1:0] CNT_ONE   = SW'(1);
  localparam logic [15:0] MAX_VEC   = 16'(max_vectors);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [width-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [15:0]       vec_q, vec_d, err_q, err_d, ff_q, ff_d;
  logic [7:0]        mask_q, mask_d;

  // Reference model of the operator block, evaluated on the held operands.
  logic [width-1:0]  m_plus, m_minus, m_bitand, m_xor, m_shr, m_qmark;
  logic              m_eq, m_lt;
  logic [7:0]        miss;

  always_comb begin
    m_plus   = a_q + b_q;
    m_minus  = a_q - b_q;
    m_bitand = a_q & b_q;
    m_xor    = a_q ^ b_q;
    m_shr    = a_q >> b_q;  // shifting by >= width already yields 0
    m_qmark  = (a_q != '0) ? b_q : c_q;
    m_eq     = (a_q == b_q);
    m_lt     = (a_q < b_q);
    // Case inequality so an X/Z on any DUT result is flagged as a failure.
    miss[0]  = (binary_plus   !== m_plus);
    miss[1]  = (binary_minus  !== m_minus);
    miss[2]  = (binary_eq     !== m_eq);
    miss[3]  = (binary_lt     !== m_lt);
    miss[4]  = (binary_bitand !== m_bitand);
    miss[5]  = (binary_xor    !== m_xor);
    miss[6]  = (binary_shr    !== m_shr);
    miss[7]  = (qmark         !== m_qmark);
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    err_d   = err_q;
    ff_d    = ff_q;
    mask_d  = mask_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // A restart from DONE keeps the LFSR where it stopped.
        if (start) begin
          state_d = S_DRIVE;
          vec_d   = '0;
          err_d   = '0;
          ff_d    = 16'hFFFF;
          mask_d  = '0;
        end
      end
      S_DRIVE: begin
        a_d     = lfsr_q[width-1:0];
        b_d     = lfsr_q[2*width-1:width];
        c_d     = lfsr_q[3*width-1:2*width];
        lfsr_d  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'd0);
        cnt_d   = SETTLE_LD;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == CNT_ONE) state_d = S_CHECK;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      S_CHECK: begin
        if (|miss) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          // err_count still zero means this is the run's first failing vector.
          if (err_q == 16'd0) begin
            ff_d   = vec_q;
            mask_d = miss;
          end
        end
        vec_d   = vec_q + 16'd1;
        state_d = (vec_q + 16'd1 == MAX_VEC) ? S_DONE : S_DRIVE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      ff_q    <= 16'hFFFF;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      mask_q  <= mask_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign c          = c_q;
  assign busy       = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done       = (state_q == S_DONE);
  assign pass       = (state_q == S_DONE) && (err_q == 16'd0);
  assign vec_count  = vec_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign fail_mask  = mask_q;

endmodule

// File: tb/tb_ops_stim_check.sv
// Purpose: directed bench for ops_stim_check with a behavioural operator block behind each instance.
// Latency: checks run length of max_vectors x (2 + settle) cycles and first-vector operands.
// Backpressure: none; faults are injected into the behavioural operator block per instance.
module tb_ops_stim_check;

  localparam int LIMIT = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  bit   fault1 = 1'b0;  // plus bit 0 stuck at 0 on instance 1
  bit   fault2 = 1'b1;  // qmark corrupted on every vector of instance 2

  always #5 clk = ~clk;

  // Instance 1: full-length runs.
  logic [3:0]  a1, b1, c1, plus1, minus1, and1, xor1, shr1, q1;
  logic        eq1, lt1, busy1, done1, pass1;
  logic [15:0] vc1, ec1, ff1;
  logic [7:0]  fm1;
  // Instance 2: short run.
  logic [3:0]  a2, b2, c2, plus2, minus2, and2, xor2, shr2, q2;
  logic        eq2, lt2, busy2, done2, pass2;
  logic [15:0] vc2, ec2, ff2;
  logic [7:0]  fm2;

  always_comb begin
    plus1  = a1 + b1;
    if (fault1) plus1[0] = 1'b0;
    minus1 = a1 - b1;
    and1   = a1 & b1;
    xor1   = a1 ^ b1;
    shr1   = a1 >> b1;
    q1     = (a1 != 4'd0) ? b1 : c1;
    eq1    = (a1 == b1);
    lt1    = (a1 < b1);
  end

  always_comb begin
    plus2  = a2 + b2;
    minus2 = a2 - b2;
    and2   = a2 & b2;
    xor2   = a2 ^ b2;
    shr2   = a2 >> b2;
    q2     = (a2 != 4'd0) ? b2 : c2;
    // Inverted rather than X: a wrong value mismatches on every vector whether or not X survives.
    if (fault2) q2 = ~q2;
    eq2    = (a2 == b2);
    lt2    = (a2 < b2);
  end

  ops_stim_check #(.width(4), .settle(1), .seed(32'h321), .max_vectors(256)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c(c1),
    .binary_plus(plus1), .binary_minus(minus1), .binary_bitand(and1), .binary_xor(xor1),
    .binary_shr(shr1), .qmark(q1), .binary_eq(eq1), .binary_lt(lt1),
    .busy(busy1), .done(done1), .pass(pass1), .vec_count(vc1), .err_count(ec1),
    .first_fail(ff1), .fail_mask(fm1)
  );

  ops_stim_check #(.width(4), .settle(1), .seed(32'h321), .max_vectors(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .c(c2),
    .binary_plus(plus2), .binary_minus(minus2), .binary_bitand(and2), .binary_xor(xor2),
    .binary_shr(shr2), .qmark(q2), .binary_eq(eq2), .binary_lt(lt2),
    .busy(busy2), .done(done2), .pass(pass2), .vec_count(vc2), .err_count(ec2),
    .first_fail(ff2), .fail_mask(fm2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Pulse start on one instance and count cycles from the start edge until done.
  // Captures operands and status one cycle into the run (just after the DRIVE edge).
  task automatic run(input bit which, input bit pulse_settle, output int cycles,
                     output logic [3:0] fa, output logic [3:0] fb, output logic [3:0] fc,
                     output logic fbusy, output logic fpass);
    logic d;
    @(negedge clk);
    if (which) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
    cycles = 0;
    fa = '0; fb = '0; fc = '0; fbusy = 1'b0; fpass = 1'b1;
    d = 1'b0;
    while (!d && cycles < LIMIT) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 1) begin
        fa    = which ? a2 : a1;
        fb    = which ? b2 : b1;
        fc    = which ? c2 : c1;
        fbusy = which ? busy2 : busy1;
        fpass = which ? pass2 : pass1;
        if (pulse_settle) start1 = 1'b1;  // lands in SETTLE
      end
      if (cycles == 2) start1 = 1'b0;
      d = which ? done2 : done1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int          cyc, exp_err, exp_ff, k;
  logic [3:0]  fa, fb, fc, sa, sb;
  logic        fbusy, fpass;
  logic [31:0] s;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", a1, 0);
    chk("rst_b", b1, 0);
    chk("rst_c", c1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_vec", vc1, 0);
    chk("rst_err", ec1, 0);
    chk("rst_first_fail", ff1, 16'hFFFF);
    chk("rst_fail_mask", fm1, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Correct DUT, full run: first vector a=1 b=2 c=3, done 768 cycles after start.
    run(0, 0, cyc, fa, fb, fc, fbusy, fpass);
    chk("v0_a", fa, 4'h1);
    chk("v0_b", fb, 4'h2);
    chk("v0_c", fc, 4'h3);
    chk("mid_busy", fbusy, 1);
    chk("mid_pass", fpass, 0);
    chk("run_cycles", cyc, 768);
    chk("run_vec", vc1, 256);
    chk("run_err", ec1, 0);
    chk("run_pass", pass1, 1);
    chk("run_busy", busy1, 0);
    chk("run_first_fail", ff1, 16'hFFFF);
    chk("run_fail_mask", fm1, 0);

    // Restart from DONE continues the LFSR: first operands come from step 256.
    s = 32'h321;
    for (int i = 0; i < 256; i++) s = lfsr_adv(s);
    run(0, 0, cyc, fa, fb, fc, fbusy, fpass);
    chk("cont_a", fa, s[3:0]);
    chk("cont_b", fb, s[7:4]);
    chk("cont_c", fc, s[11:8]);
    chk("cont_vec", vc1, 256);
    chk("cont_err", ec1, 0);

    // Extra start pulse in SETTLE changes nothing.
    do_reset();
    run(0, 1, cyc, fa, fb, fc, fbusy, fpass);
    chk("ign_a", fa, 4'h1);
    chk("ign_cycles", cyc, 768);
    chk("ign_vec", vc1, 256);
    chk("ign_err", ec1, 0);
    chk("ign_pass", pass1, 1);

    // plus bit 0 stuck at 0: vector 0 (1+2=3) is already odd.
    exp_err = 0;
    exp_ff  = -1;
    s = 32'h321;
    for (k = 0; k < 256; k++) begin
      sa = s[3:0];
      sb = s[7:4];
      if (((sa + sb) & 4'h1) != 4'h0) begin
        exp_err++;
        if (exp_ff < 0) exp_ff = k;
      end
      s = lfsr_adv(s);
    end
    fault1 = 1'b1;
    do_reset();
    run(0, 0, cyc, fa, fb, fc, fbusy, fpass);
    chk("stuck_first_fail", ff1, 0);
    chk("stuck_first_model", ff1, exp_ff);
    chk("stuck_err", ec1, exp_err);
    chk("stuck_mask", fm1, 8'h01);
    chk("stuck_pass", pass1, 0);
    chk("stuck_done", done1, 1);
    fault1 = 1'b0;

    // Corrupted qmark on the 10-vector instance.
    run(1, 0, cyc, fa, fb, fc, fbusy, fpass);
    chk("qm_cycles", cyc, 30);
    chk("qm_vec", vc2, 10);
    chk("qm_err", ec2, 10);
    chk("qm_first_fail", ff2, 0);
    chk("qm_mask", fm2, 8'h80);
    chk("qm_pass", pass2, 0);

    // Asynchronous reset at vector 5, then restart from the seed.
    do_reset();
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    while (vc1 != 16'd5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reach_vec5", vc1, 5);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy1, 0);
    chk("arst_vec", vc1, 0);
    chk("arst_a", a1, 0);
    chk("arst_first_fail", ff1, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 0, cyc, fa, fb, fc, fbusy, fpass);
    chk("rs_a", fa, 4'h1);
    chk("rs_b", fb, 4'h2);
    chk("rs_c", fc, 4'h3);
    chk("rs_vec", vc1, 256);
    chk("rs_err", ec1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
